// File: rtl/pwm_meter.sv
// pwm_meter: recovers high time, period and duty of an async PWM input.
// Restoring divider yields duty = high*2^DUTY_WIDTH/period.
module pwm_meter #(
  parameter int CNT_WIDTH   = 24,
  parameter int DUTY_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pwm_in,
  output logic [DUTY_WIDTH-1:0] duty,
  output logic [CNT_WIDTH-1:0]  high_cnt,
  output logic [CNT_WIDTH-1:0]  period_cnt,
  output logic                  valid,
  output logic                  stuck_high,
  output logic                  stuck_low,
  output logic                  overrun
);

  localparam int IW  = $clog2(TIMEOUT + 1);
  localparam int DCW = $clog2(DUTY_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] CMAX  = '1;
  localparam logic [IW-1:0]        TO    = IW'(TIMEOUT);
  localparam logic [IW-1:0]        TO_M1 = IW'(TIMEOUT - 1);
  localparam logic [DCW-1:0]       DLAST = DCW'(DUTY_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    if (v == CMAX) return v;
    return v + CNT_WIDTH'(1);
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic [IW-1:0]          r_idle;
  logic                   w_tmo;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_hi;
  logic [CNT_WIDTH-1:0]   r_per;
  logic [CNT_WIDTH-1:0]   w_hi_nxt;
  logic [CNT_WIDTH-1:0]   w_per_nxt;
  logic                   w_close;
  logic                   w_start;

  logic                   r_busy;
  logic [DCW-1:0]         r_dcnt;
  logic [CNT_WIDTH-1:0]   r_rem;
  logic [CNT_WIDTH-1:0]   r_den;
  logic [DUTY_WIDTH-1:0]  r_q;
  logic [CNT_WIDTH:0]     w_shift;
  logic                   w_ge;
  logic [CNT_WIDTH-1:0]   w_rem_nxt;
  logic [DUTY_WIDTH-1:0]  w_q_nxt;
  logic                   w_div_last;

  logic [DUTY_WIDTH-1:0]  r_duty;
  logic [CNT_WIDTH-1:0]   r_high_cnt;
  logic [CNT_WIDTH-1:0]   r_period_cnt;
  logic                   r_valid;
  logic                   r_stuck_high;
  logic                   r_stuck_low;
  logic                   r_overrun;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;
  assign w_tmo  = ~w_rise & ~w_fall & (r_idle == TO_M1);

  // Synchroniser and edge register; left unreset so a reset does not
  // fabricate a rising edge while the input is already high.
  always_ff @(posedge clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
    r_s_d  <= w_s;
  end

  // Cycles since the last synchronised edge, saturating at TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle <= '0;
    end else if (w_rise | w_fall) begin
      r_idle <= '0;
    end else if (r_idle != TO) begin
      r_idle <= r_idle + IW'(1);
    end
  end

  // Measurement state and high/period counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hi    <= '0;
      r_per   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hi    <= w_hi_nxt;
      r_per   <= w_per_nxt;
    end
  end

  // Next state: count high and period, close a period on rise in LOW.
  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi;
    w_per_nxt   = r_per;
    w_close     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
          w_hi_nxt    = CNT_WIDTH'(1);
          w_per_nxt   = CNT_WIDTH'(1);
        end
      end
      HIGH: begin
        w_per_nxt = sat_inc(r_per);
        if (w_fall) begin
          w_state_nxt = LOW;
        end else begin
          w_hi_nxt = sat_inc(r_hi);
        end
      end
      LOW: begin
        if (w_rise) begin
          w_close     = 1'b1;
          w_state_nxt = HIGH;
          w_hi_nxt    = CNT_WIDTH'(1);
          w_per_nxt   = CNT_WIDTH'(1);
        end else begin
          w_per_nxt = sat_inc(r_per);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_tmo) w_state_nxt = IDLE;
  end

  assign w_start    = w_close & ~r_busy;
  assign w_shift    = {r_rem, 1'b0};
  assign w_ge       = w_shift >= {1'b0, r_den};
  assign w_rem_nxt  = w_ge ? CNT_WIDTH'(w_shift - {1'b0, r_den})
                           : w_shift[CNT_WIDTH-1:0];
  assign w_q_nxt    = {r_q[DUTY_WIDTH-2:0], w_ge};
  assign w_div_last = r_busy & (r_dcnt == DLAST) & ~w_tmo;

  // Restoring divider: remainder starts at high, one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_dcnt <= '0;
      r_rem  <= '0;
      r_den  <= '0;
      r_q    <= '0;
    end else if (w_tmo) begin
      r_busy <= 1'b0;
    end else if (w_start) begin
      r_busy <= 1'b1;
      r_dcnt <= '0;
      r_rem  <= r_hi;
      r_den  <= r_per;
      r_q    <= '0;
    end else if (r_busy) begin
      r_rem  <= w_rem_nxt;
      r_q    <= w_q_nxt;
      r_dcnt <= r_dcnt + DCW'(1);
      if (r_dcnt == DLAST) r_busy <= 1'b0;
    end
  end

  // Published results, strobes and stuck flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty       <= '0;
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
      r_valid      <= 1'b0;
      r_stuck_high <= 1'b0;
      r_stuck_low  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= w_close & r_busy;
      if (w_tmo) begin
        r_valid      <= 1'b1;
        r_stuck_high <= w_s;
        r_stuck_low  <= ~w_s;
        r_duty       <= w_s ? '1 : '0;
        r_high_cnt   <= '0;
        r_period_cnt <= '0;
      end else begin
        if (w_rise | w_fall) begin
          r_stuck_high <= 1'b0;
          r_stuck_low  <= 1'b0;
        end
        if (w_start) begin
          r_high_cnt   <= r_hi;
          r_period_cnt <= r_per;
        end
        if (w_div_last) begin
          r_duty  <= w_q_nxt;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign duty       = r_duty;
  assign high_cnt   = r_high_cnt;
  assign period_cnt = r_period_cnt;
  assign valid      = r_valid;
  assign stuck_high = r_stuck_high;
  assign stuck_low  = r_stuck_low;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_pwm_meter.sv
// tb_pwm_meter: table-driven PWM trains with a scoreboard of expected
// valid/overrun events, plus reset and stuck-input sequences.
module tb_pwm_meter;

  localparam int CW = 24;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 1000;

  logic          clk;
  logic          rst;
  logic          pwm_in;
  logic [DW-1:0] duty;
  logic [CW-1:0] high_cnt;
  logic [CW-1:0] period_cnt;
  logic          valid;
  logic          stuck_high;
  logic          stuck_low;
  logic          overrun;

  pwm_meter #(
    .CNT_WIDTH  (CW),
    .DUTY_WIDTH (DW),
    .SYNC_STAGES(SS),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .duty      (duty),
    .high_cnt  (high_cnt),
    .period_cnt(period_cnt),
    .valid     (valid),
    .stuck_high(stuck_high),
    .stuck_low (stuck_low),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int duty;
    int hi;
    int per;
    bit sh;
    bit sl;
  } exp_t;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int duty;
    int hc;
    int pc;
  } vec_t;

  exp_t exp_q[$];
  int   ov_q[$];
  int   total = 0;
  int   bad   = 0;

  bit   prev      = 1'b0;
  bit   armed     = 1'b0;
  int   free_c    = 0;
  int   last_rise = 0;
  int   last_fall = 0;
  int   last_edge = 0;

  function automatic void chk(string name, longint act, longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endfunction

  // Drive one cycle of pwm_in and predict the events it causes.
  task automatic drive(input bit v);
    int c;
    int h;
    int p;
    exp_t e;
    c = cyc + SS;
    pwm_in = v;
    if (v && !prev) begin
      if (armed) begin
        h = last_fall - last_rise;
        p = c - last_rise;
        if (c >= free_c) begin
          e.cyc  = c + DW + 1;
          e.duty = int'((longint'(h) << DW) / p);
          e.hi   = h;
          e.per  = p;
          e.sh   = 1'b0;
          e.sl   = 1'b0;
          exp_q.push_back(e);
          free_c = c + DW + 1;
        end else begin
          ov_q.push_back(c + 1);
        end
      end
      armed     = 1'b1;
      last_rise = c;
      last_edge = c;
    end else if (!v && prev) begin
      last_fall = c;
      last_edge = c;
    end
    prev = v;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  task automatic train(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_duty"}, duty, 0);
    chk({tag, "_high"}, high_cnt, 0);
    chk({tag, "_period"}, period_cnt, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_stuck_hi"}, stuck_high, 0);
    chk({tag, "_stuck_lo"}, stuck_low, 0);
  endtask

  task automatic do_reset(input int n, input string tag);
    rst = 1'b1;
    exp_q.delete();
    ov_q.delete();
    armed  = 1'b0;
    free_c = 0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero(tag);
  endtask

  task automatic push_timeout(input bit s);
    exp_t e;
    e.cyc  = last_edge + TO + 1;
    e.duty = s ? (1 << DW) - 1 : 0;
    e.hi   = 0;
    e.per  = 0;
    e.sh   = s;
    e.sl   = ~s;
    exp_q.push_back(e);
    armed  = 1'b0;
    free_c = 0;
  endtask

  // Scoreboard: pop and compare whenever the DUT strobes.
  always @(negedge clk) begin
    exp_t e;
    int   oc;
    if (valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("duty", duty, e.duty);
        chk("high_cnt", high_cnt, e.hi);
        chk("period_cnt", period_cnt, e.per);
        chk("stuck_high", stuck_high, e.sh);
        chk("stuck_low", stuck_low, e.sl);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      chk("missed_valid", valid, 1);
      void'(exp_q.pop_front());
    end
    if (overrun) begin
      if (ov_q.size() == 0) begin
        chk("unexpected_overrun", overrun, 0);
      end else begin
        oc = ov_q.pop_front();
        chk("overrun_cycle", cyc, oc);
      end
    end else if (ov_q.size() != 0 && ov_q[0] < cyc) begin
      chk("missed_overrun", overrun, 1);
      void'(ov_q.pop_front());
    end
  end

  initial begin
    #(40 * 100000);
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    vt[0] = '{100, 300, 4, 64, 100, 400};
    vt[1] = '{128, 128, 3, 128, 128, 256};
    vt[2] = '{2, 2, 12, 128, 2, 4};
    vt[3] = '{1, 3, 4, 64, 1, 4};
    vt[4] = '{3, 1, 4, 192, 3, 4};
    vt[5] = '{37, 200, 3, 39, 37, 237};

    pwm_in = 1'b0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset(3, "reset");

    for (int r = 0; r < 6; r++) begin
      train(vt[r].hi, vt[r].lo, vt[r].reps);
      hold(1'b0, DW + SS + 4);
      chk($sformatf("row%0d_duty", r), duty, vt[r].duty);
      chk($sformatf("row%0d_high", r), high_cnt, vt[r].hc);
      chk($sformatf("row%0d_period", r), period_cnt, vt[r].pc);
    end

    hold(1'b1, 50);
    do_reset(1, "rst_high");
    hold(1'b1, 20);
    hold(1'b0, 30);
    train(40, 60, 3);
    hold(1'b0, DW + SS + 4);
    chk("after_rst_high_period", period_cnt, 100);
    chk("after_rst_high_duty", duty, 102);

    hold(1'b1, 40);
    hold(1'b0, 60);
    hold(1'b1, 4);
    do_reset(1, "rst_div");
    hold(1'b1, 30);
    hold(1'b0, 60);
    train(40, 60, 3);
    hold(1'b0, DW + SS + 4);

    push_timeout(1'b0);
    hold(1'b0, TO + 10);
    chk("stuck_low_set", stuck_low, 1);
    chk("stuck_low_hi", stuck_high, 0);
    hold(1'b1, 5);
    chk("stuck_low_clear", stuck_low, 0);
    hold(1'b1, 45);
    hold(1'b0, 150);
    train(50, 200 - 50, 2);
    hold(1'b0, DW + SS + 4);
    chk("post_stuck_duty", duty, 64);
    chk("post_stuck_period", period_cnt, 200);

    drive(1'b1);
    push_timeout(1'b1);
    hold(1'b1, TO + 10);
    chk("stuck_high_set", stuck_high, 1);
    chk("stuck_high_duty", duty, 255);
    chk("stuck_high_period", period_cnt, 0);
    hold(1'b0, 5);
    chk("stuck_high_clear", stuck_high, 0);

    hold(1'b0, 20);
    chk("pending_valid", exp_q.size(), 0);
    chk("pending_overrun", ov_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
